ibuf_queue: RTL and testbench
=============================

# ibuf_queue

Parametrised instruction prefetch queue with a word-granular consume port. The bus interface unit writes DATA_W-bit fetch words into a circular RAM. The decoder sees a registered two-word window `q` starting at the oldest unconsumed word and retires 0, 1 or 2 words per cycle. It adds occupancy tracking, back-pressure, flush and optional write-to-window bypass to the fixed 16x32-in / 64-out instruction buffer RAM, which has none of these.

## Interface
- DATA_W, 32: width of one fetch word.
- DEPTH_LOG2, 4: log2 of the queue depth; DEPTH = 2**DEPTH_LOG2, minimum 2.
- clk  in  1  sole clock; all state updates on posedge.
- reset  in  1  synchronous, active-high reset.
- flush  in  1  discard all contents (branch/jump taken).
- wr_data  in  DATA_W  fetch word.
- wr_valid  in  1  wr_data present.
- wr_ready  out  1  queue can accept a word this cycle.
- rd_adv  in  2  words retired this cycle (0, 1, 2; 3 is treated as 2).
- q  out  2*DATA_W  window {word[rd+1], word[rd]}, oldest word in low half.
- q_avail  out  2  valid words in q (0, 1, 2).
- level  out  DEPTH_LOG2+1  words stored (0..DEPTH).
- rd_err  out  1  one-cycle pulse: rd_adv exceeded q_avail.

## Operation
- Pointers: wr_ptr and rd_ptr are each DEPTH_LOG2+1 bits wide, with the MSB as wrap bit. level = wr_ptr - rd_ptr, mod 2**(DEPTH_LOG2+1).
- wr_ready = (level != DEPTH), from registered state only. Slots freed by rd_adv in the same cycle are not usable until the next cycle.
- Write fire = wr_valid & wr_ready & ~flush. On fire: ram[wr_ptr[DEPTH_LOG2-1:0]] <= wr_data, and wr_ptr increments.
- Consume:
  - adv_eff = min(rd_adv, q_avail); rd_ptr += adv_eff.
  - If rd_adv > q_avail and flush = 0, rd_err = 1 next cycle. Otherwise rd_err = 0 next cycle.
- Window update (registered each cycle):
  - rd_n and level_n are the post-update pointer and level.
  - q is loaded from the RAM at index rd_n and rd_n+1, each mod DEPTH.
  - q_avail = min(vis_n, 2). vis_n is the count of words visible in the window (see Configuration).
  - Halves of q beyond q_avail hold don't-care data. The bench must not check them.
- Flush (flush = 1, higher priority than writes and consumes):
  - Next cycle: wr_ptr = rd_ptr = 0, level = 0, q_avail = 0, rd_err = 0.
  - A write presented in the flush cycle is dropped.
  - RAM contents are not cleared.
- Reset: same state as flush. Additionally q = 0 and wr_ready = 1 from the first cycle after reset, and rd_err = 0.
- Simultaneous write and consume with level = DEPTH: the write is refused (wr_ready = 0), the consume proceeds, and level drops by adv_eff.
- Wrap-around: the window straddles the boundary seamlessly. For example, with rd at index DEPTH-1, q = {ram[0], ram[DEPTH-1]}.

## Timing
- The decoder acts on q/q_avail of cycle t by driving rd_adv in cycle t. q/q_avail in cycle t+1 already reflect that consume. The window is never stale.
- Write-to-visible latency: 2 cycles without bypass, 1 cycle with bypass.
- level updates 1 cycle after the write/consume edge and always includes writes fired in that cycle.
- Throughput: 1 word in and up to 2 words out per cycle, sustained.

## Configuration
- IBUF_BYPASS_EN defined:
  - vis_n = level_n.
  - A word written in the current cycle whose slot is rd_n or rd_n+1 is forwarded from wr_data into the matching half of q. This also covers writing into an empty queue.
- Undefined:
  - vis_n = level_n - write_fire. The word written this cycle first becomes visible one cycle later.
  - There is no wr_data path into q.
- level, wr_ready and flush behaviour are identical in both builds.

## Test plan
- Reset, then write 0x11111111, 0x22222222 on consecutive cycles with rd_adv = 0:
  - Bypass build: q_avail = 1 after the first write edge.
  - Non-bypass build: q_avail = 1 one cycle later.
  - Both builds: q = 0x22222222_11111111 with q_avail = 2 once settled, and level = 2.
- Fill 16 words 0x0..0xF: wr_ready = 0 at level = 16. Then hold wr_valid = 1 and rd_adv = 2 for 1 cycle: level = 14, no write accepted that cycle, and the write is accepted the next cycle.
- Steady state with wr_valid = 1 and rd_adv = 1 continuously, over 40 words: the words appear in q[31:0] in order with none dropped or duplicated, including across the index 15 -> 0 wrap.
- level = 1, rd_adv = 2: rd_ptr advances by 1, rd_err = 1 for exactly one cycle, then level = 0 and q_avail = 0.
- level = 5, flush = 1 with wr_valid = 1 and rd_adv = 2 in the same cycle: next cycle level = 0, q_avail = 0, rd_err = 0, and the write is discarded.
- Assert reset with level = 9: next cycle level = 0, q = 0, wr_ready = 1, and stale RAM data never appears in the window afterwards.

Source files
------------

// File: rtl/ibuf_queue.sv
// ibuf_queue: circular prefetch queue with a registered two-word decode window.
// Optional write-to-window forwarding is enabled by defining IBUF_BYPASS_EN.
module ibuf_queue #(
    parameter int DATA_W = 32,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  flush,
    input  logic [DATA_W-1:0]     wr_data,
    input  logic                  wr_valid,
    output logic                  wr_ready,
    input  logic [1:0]            rd_adv,
    output logic [2*DATA_W-1:0]   q,
    output logic [1:0]            q_avail,
    output logic [DEPTH_LOG2:0]   level,
    output logic                  rd_err
);
    localparam int PW = DEPTH_LOG2 + 1;
    localparam logic [PW-1:0] DEPTH = {1'b1, {DEPTH_LOG2{1'b0}}};

    logic [DATA_W-1:0] ram [1<<DEPTH_LOG2];
    logic [PW-1:0] wr_ptr, rd_ptr, rd_n, wr_n, level_n, vis_n;
    logic [DEPTH_LOG2-1:0] i0, i1;
    logic [1:0] adv, adv_eff, avail_n;
    logic [DATA_W-1:0] lo, hi;
    logic fire;

    assign level = wr_ptr - rd_ptr;
    assign wr_ready = level != DEPTH;

    // The window is computed from the post-update read pointer so it is never stale.
    always_comb begin
        fire = wr_valid & wr_ready & ~flush;
        adv = rd_adv == 2'd3 ? 2'd2 : rd_adv;
        adv_eff = adv > q_avail ? q_avail : adv;
        rd_n = flush ? '0 : rd_ptr + PW'(adv_eff);
        wr_n = flush ? '0 : wr_ptr + PW'(fire);
        level_n = wr_n - rd_n;
`ifdef IBUF_BYPASS_EN
        vis_n = level_n;
`else
        vis_n = level_n - PW'(fire);
`endif
        avail_n = vis_n >= PW'(2) ? 2'd2 : vis_n[1:0];
        i0 = rd_n[DEPTH_LOG2-1:0];
        i1 = i0 + DEPTH_LOG2'(1);
`ifdef IBUF_BYPASS_EN
        lo = fire && wr_ptr[DEPTH_LOG2-1:0] == i0 ? wr_data : ram[i0];
        hi = fire && wr_ptr[DEPTH_LOG2-1:0] == i1 ? wr_data : ram[i1];
`else
        lo = ram[i0];
        hi = ram[i1];
`endif
    end

    always_ff @(posedge clk)
        if (fire) ram[wr_ptr[DEPTH_LOG2-1:0]] <= wr_data;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            q <= '0;
            q_avail <= '0;
            rd_err <= 1'b0;
        end else begin
            wr_ptr <= wr_n;
            rd_ptr <= rd_n;
            q <= {hi, lo};
            q_avail <= avail_n;
            rd_err <= ~flush & (adv > q_avail);
        end
    end
endmodule

// File: tb/tb_ibuf_queue.sv
// tb_ibuf_queue: scoreboard bench; written words are queued and a monitor
// checks every consumed window word against them in order.
module tb_ibuf_queue;
    logic clk = 0, reset = 1, flush = 0, wr_valid = 0, wr_ready, rd_err;
    logic [31:0] wr_data = 0;
    logic [1:0] rd_adv = 0, q_avail;
    logic [63:0] q;
    logic [4:0] level;
    int checks = 0, failures = 0, errs, k;
    logic [31:0] exp_q[$];
    logic [31:0] w, e;

    ibuf_queue dut (
        .clk(clk), .reset(reset), .flush(flush), .wr_data(wr_data),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .rd_adv(rd_adv),
        .q(q), .q_avail(q_avail), .level(level), .rd_err(rd_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exv);
        checks++;
        if (act !== exv) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exv);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic put(input logic [31:0] d);
        wr_data = d;
        wr_valid = 1;
        exp_q.push_back(d);
        step();
        wr_valid = 0;
    endtask

    task automatic drain();
        for (int n = 0; n < 40 && level != 0; n++) begin
            rd_adv = q_avail;
            step();
        end
        rd_adv = 0;
        chk("drain_level", level, 0);
    endtask

    // Monitor: every word retired by the decoder must be the next one written.
    always @(negedge clk) begin
        if (!reset && !flush) begin
            k = rd_adv == 2'd3 ? 2 : int'(rd_adv);
            if (k > int'(q_avail)) k = int'(q_avail);
            for (int j = 0; j < k; j++) begin
                w = q[j*32 +: 32];
                if (exp_q.size() == 0) begin
                    checks++;
                    failures++;
                    $display("FAIL word_extra: got %h expected none", w);
                end else begin
                    e = exp_q.pop_front();
                    chk("word", {32'b0, w}, {32'b0, e});
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        step();
        step();
        chk("rst_level", level, 0);
        chk("rst_q", q, 0);
        chk("rst_ready", wr_ready, 1);
        chk("rst_avail", q_avail, 0);
        chk("rst_err", rd_err, 0);
        reset = 0;

        wr_data = 32'h11111111; wr_valid = 1; exp_q.push_back(wr_data);
        step();
        chk("lat_level1", level, 1);
`ifdef IBUF_BYPASS_EN
        chk("lat_avail1", q_avail, 1);
        chk("lat_q_lo", q[31:0], 32'h11111111);
`else
        chk("lat_avail1", q_avail, 0);
`endif
        wr_data = 32'h22222222; exp_q.push_back(wr_data);
        step();
        wr_valid = 0;
        chk("lat_level2", level, 2);
`ifdef IBUF_BYPASS_EN
        chk("lat_avail2", q_avail, 2);
`else
        chk("lat_avail2", q_avail, 1);
`endif
        step();
        chk("settle_avail", q_avail, 2);
        chk("settle_q", q, 64'h22222222_11111111);
        chk("settle_level", level, 2);
        rd_adv = 2;
        step();
        rd_adv = 0;
        chk("pair_level", level, 0);
        chk("pair_avail", q_avail, 0);
        chk("pair_err", rd_err, 0);

        for (int i = 0; i < 16; i++) put(i);
        chk("full_level", level, 16);
        chk("full_ready", wr_ready, 0);
        wr_data = 32'h100; wr_valid = 1; rd_adv = 2;
        step();
        chk("full_cons_level", level, 14);
        chk("full_cons_ready", wr_ready, 1);
        exp_q.push_back(wr_data); rd_adv = 0;
        step();
        wr_valid = 0;
        chk("full_retry_level", level, 15);
        drain();

        errs = 0;
        for (int i = 0; i < 40; i++) begin
            wr_data = 32'h1000 + i; wr_valid = 1; exp_q.push_back(wr_data);
            rd_adv = q_avail != 0 ? 2'd1 : 2'd0;
            step();
            if (rd_err) errs++;
        end
        wr_valid = 0;
        chk("steady_rd_err", errs, 0);
        drain();

        put(32'hC0C0C0C0);
        for (int n = 0; n < 4 && q_avail != 1; n++) step();
        chk("l1_avail", q_avail, 1);
        rd_adv = 2;
        step();
        rd_adv = 0;
        chk("over_err", rd_err, 1);
        chk("over_level", level, 0);
        chk("over_avail", q_avail, 0);
        step();
        chk("over_err_clear", rd_err, 0);

        for (int i = 0; i < 5; i++) put(32'h5000 + i);
        chk("pre_flush_level", level, 5);
        flush = 1; wr_valid = 1; wr_data = 32'hDEADBEEF; rd_adv = 2;
        exp_q.delete();
        step();
        flush = 0; wr_valid = 0; rd_adv = 0;
        chk("flush_level", level, 0);
        chk("flush_avail", q_avail, 0);
        chk("flush_err", rd_err, 0);
        chk("flush_ready", wr_ready, 1);
        step();
        chk("flush_drop_level", level, 0);
        put(32'hD00DD00D);
        for (int n = 0; n < 4 && q_avail != 1; n++) step();
        chk("post_flush_avail", q_avail, 1);
        drain();

        for (int i = 0; i < 9; i++) put(32'h9000 + i);
        chk("pre_rst_level", level, 9);
        reset = 1;
        exp_q.delete();
        step();
        reset = 0;
        chk("rst2_level", level, 0);
        chk("rst2_q", q, 0);
        chk("rst2_ready", wr_ready, 1);
        chk("rst2_avail", q_avail, 0);
        chk("rst2_err", rd_err, 0);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("rst2_idle_avail", q_avail, 0);
        end
        put(32'hEEEE0001);
        put(32'hEEEE0002);
        step();
        chk("rst2_new_q", q, 64'hEEEE0002_EEEE0001);
        drain();

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
